// File: rtl/mc_if.sv
// mc_if: control/datapath bundle for multicycle_control (master = controller, slave = datapath)
// opcode/mem_ready flow into the controller; strobes, state and instret flow out.
interface mc_if #(
  parameter int ALUOP_W = 6,
  parameter int CNT_W = 32
);
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write;
  logic pc_write_cond;
  logic branch_ne;
  logic iord;
  logic mem_read;
  logic mem_write;
  logic [1:0] mem_size;
  logic ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic [CNT_W-1:0] instret;
  logic trap;
  modport master (
    input opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, mem_size,
    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
    state, instret, trap
  );
  modport slave (
    output opcode, mem_ready,
    input pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, mem_size,
    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
    state, instret, trap
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with memory-ready stalls and retired count
// Ports: clk, reset (sync, active-high), bus (mc_if.master: opcode/mem_ready in, datapath strobes,
// state, instret, trap out). Define MC_CTRL_TRAP_EN to enable the TRAP state for undefined
// opcodes and memory-wait timeouts; without it unknown opcodes retire as NOPs and waits never end.
module multicycle_control #(
  parameter int ALUOP_W = 6,
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  mc_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
    MEM_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7, EXEC_I = 4'd8, WB_I = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, TRAP = 4'd12;
`ifdef MC_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic [3:0] st, nx;
  logic [TIMEOUT_W-1:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic [5:0] op;
  logic rdy, waiting, timeout, retire, is_r, is_i, is_ld, is_st, is_br, is_j, jal;
  assign op = bus.opcode;
  assign rdy = bus.mem_ready;
  assign is_r = op == 6'b000000;
  assign is_i = op inside {6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011111, 6'b001111};
  assign is_ld = op inside {6'b100011, 6'b100000, 6'b100001};
  assign is_st = op inside {6'b101011, 6'b101000, 6'b101001};
  assign is_br = op inside {6'b000100, 6'b000101, 6'b000001};
  assign is_j = op inside {6'b000010, 6'b000011};
  assign jal = op == 6'b000011;
  assign waiting = (st == FETCH || st == MEM_RD || st == MEM_WR) && !rdy;
  assign timeout = TRAP_EN && waiting && &wcnt;
  // Every path back to FETCH retires an instruction, except the trap vector path.
  assign retire = nx == FETCH && st != FETCH && st != TRAP;
  always_comb begin
    nx = st;
    case (st)
      FETCH: nx = timeout ? TRAP : rdy ? DECODE : FETCH;
      DECODE: nx = is_r ? EXEC_R : is_i ? EXEC_I : (is_ld || is_st) ? MEM_ADDR :
        is_br ? BRANCH : is_j ? JUMP : TRAP_EN ? TRAP : FETCH;
      MEM_ADDR: nx = is_ld ? MEM_RD : MEM_WR;
      MEM_RD: nx = timeout ? TRAP : rdy ? MEM_WB : MEM_RD;
      MEM_WR: nx = timeout ? TRAP : rdy ? FETCH : MEM_WR;
      EXEC_R: nx = WB_R;
      EXEC_I: nx = WB_I;
      default: nx = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      wcnt <= '0;
      cnt <= '0;
    end else begin
      st <= nx;
      wcnt <= nx != st ? '0 : (waiting && !(&wcnt)) ? wcnt + 1'b1 : wcnt;
      cnt <= cnt + CNT_W'(retire);
    end
  end
  // Strobes are decoded from the current state and forced low while reset is asserted,
  // which also drops any memory request in flight.
  always_comb begin
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_size = 2'b00;
    bus.ir_write = 1'b0;
    bus.reg_dst = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.reg_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'd0;
    bus.alu_op = '0;
    bus.pc_src = 2'd0;
    bus.trap = 1'b0;
    if (!reset)
      case (st)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.pc_write = rdy;
          bus.ir_write = rdy;
        end
        DECODE: bus.alu_src_b = 2'd3;
        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
        end
        MEM_RD, MEM_WR: begin
          bus.iord = 1'b1;
          bus.mem_read = st == MEM_RD;
          bus.mem_write = st == MEM_WR;
          bus.mem_size = op[1] ? 2'b00 : op[0] ? 2'b01 : 2'b10;
        end
        MEM_WB: begin
          bus.reg_write = 1'b1;
          bus.mem_to_reg = 2'd1;
        end
        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = ALUOP_W'(6'b000010);
        end
        WB_R: begin
          bus.reg_write = 1'b1;
          bus.reg_dst = 2'd1;
        end
        EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
          bus.alu_op = ALUOP_W'(op);
        end
        WB_I: bus.reg_write = 1'b1;
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.pc_write_cond = 1'b1;
          bus.pc_src = 2'd1;
          bus.branch_ne = op == 6'b000101;
          bus.alu_op = ALUOP_W'(op == 6'b000101 ? 6'b000101 : op == 6'b000001 ? 6'b111111 : 6'b000001);
        end
        JUMP: begin
          bus.pc_write = 1'b1;
          bus.pc_src = 2'd2;
          bus.reg_write = jal;
          bus.reg_dst = jal ? 2'd2 : 2'd0;
          bus.mem_to_reg = jal ? 2'd2 : 2'd0;
        end
        TRAP: begin
          bus.trap = TRAP_EN;
          bus.pc_write = 1'b1;
          bus.pc_src = 2'd3;
        end
        default: ;
      endcase
    bus.state = reset ? 4'd0 : st;
    bus.instret = reset ? '0 : cnt;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked against a per-instruction phase model
module tb_multicycle_control;
  typedef struct packed {
    logic trap, pcw, pcwc, bne, iord, mr, mw;
    logic [1:0] msz;
    logic irw;
    logic [1:0] rdst, m2r;
    logic rw, asa;
    logic [1:0] asb;
    logic [5:0] aluop;
    logic [1:0] pcsrc;
  } outs_t;
  typedef struct packed {
    logic [3:0] st;
    logic rdy;
    outs_t o;
  } cyc_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] n_ret = '0;
  logic [5:0] cur_op = '0;
  cyc_t q[$];
  logic [5:0] ops[17] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011111,
    6'b001111, 6'b100011, 6'b100000, 6'b100001, 6'b101011, 6'b101000, 6'b101001, 6'b000100,
    6'b000101, 6'b000001, 6'b000011};
  mc_if #(.ALUOP_W(6), .CNT_W(32)) bus();
  multicycle_control #(.ALUOP_W(6), .TIMEOUT_W(4), .CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic outs_t dut_outs();
    return {bus.trap, bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.iord, bus.mem_read,
      bus.mem_write, bus.mem_size, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
      bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src};
  endfunction
  task automatic push(input logic [3:0] st, input logic rdy, input outs_t o);
    q.push_back('{st, rdy, o});
  endtask
  task automatic step(input cyc_t e);
    @(negedge clk);
    bus.opcode = cur_op;
    bus.mem_ready = e.rdy;
    #1;
    check($sformatf("state op%b", cur_op), 64'(bus.state), 64'(e.st));
    check($sformatf("outs op%b st%0d", cur_op, e.st), 64'(dut_outs()), 64'(e.o));
    check("instret", 64'(bus.instret), 64'(n_ret));
  endtask
  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      6'b100001, 6'b101001: return 2'b01;
      6'b100000, 6'b101000: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
  task automatic mem_phase(input logic [5:0] op, input bit load, input int mw);
    outs_t o;
    o = '0;
    o.asa = 1'b1;
    o.asb = 2'd2;
    push(4'd2, 1'($urandom), o);
    o = '0;
    o.iord = 1'b1;
    o.mr = load;
    o.mw = !load;
    o.msz = size_of(op);
    for (int i = 0; i < mw; i++) push(load ? 4'd3 : 4'd5, 1'b0, o);
    push(load ? 4'd3 : 4'd5, 1'b1, o);
    if (load) begin
      o = '0;
      o.rw = 1'b1;
      o.m2r = 2'd1;
      push(4'd4, 1'($urandom), o);
    end
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t o;
    bit ret;
    ret = 1'b1;
    cur_op = op;
    q.delete();
    o = '0;
    o.mr = 1'b1;
    o.asb = 2'd1;
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, o);
    o.pcw = 1'b1;
    o.irw = 1'b1;
    push(4'd0, 1'b1, o);
    o = '0;
    o.asb = 2'd3;
    push(4'd1, 1'($urandom), o);
    o = '0;
    case (op)
      6'b000000: begin
        o.asa = 1'b1;
        o.aluop = 6'b000010;
        push(4'd6, 1'($urandom), o);
        o = '0;
        o.rw = 1'b1;
        o.rdst = 2'd1;
        push(4'd7, 1'($urandom), o);
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011111, 6'b001111: begin
        o.asa = 1'b1;
        o.asb = 2'd2;
        o.aluop = op;
        push(4'd8, 1'($urandom), o);
        o = '0;
        o.rw = 1'b1;
        push(4'd9, 1'($urandom), o);
      end
      6'b100011, 6'b100000, 6'b100001: mem_phase(op, 1'b1, mw);
      6'b101011, 6'b101000, 6'b101001: mem_phase(op, 1'b0, mw);
      6'b000100, 6'b000101, 6'b000001: begin
        o.asa = 1'b1;
        o.pcwc = 1'b1;
        o.pcsrc = 2'd1;
        o.bne = op == 6'b000101;
        o.aluop = op == 6'b000100 ? 6'b000001 : op == 6'b000101 ? 6'b000101 : 6'b111111;
        push(4'd10, 1'($urandom), o);
      end
      6'b000010, 6'b000011: begin
        o.pcw = 1'b1;
        o.pcsrc = 2'd2;
        if (op == 6'b000011) begin
          o.rw = 1'b1;
          o.rdst = 2'd2;
          o.m2r = 2'd2;
        end
        push(4'd11, 1'($urandom), o);
      end
      default: begin
`ifdef MC_CTRL_TRAP_EN
        o.trap = 1'b1;
        o.pcw = 1'b1;
        o.pcsrc = 2'd3;
        push(4'd12, 1'($urandom), o);
        ret = 1'b0;
`endif
      end
    endcase
    foreach (q[i]) step(q[i]);
    if (ret) n_ret++;
  endtask
  initial begin
    logic [5:0] op;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 64'(bus.state), 64'd0);
    check("reset outs", 64'(dut_outs()), 64'd0);
    check("reset instret", 64'(bus.instret), 64'd0);
    reset = 1'b0;
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b000011, 0, 0);
    run_instr(6'b101000, 2, 1);
    cur_op = 6'b101011;
    @(negedge clk);
    bus.opcode = cur_op;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("pre-reset state", 64'(bus.state), 64'd5);
    check("pre-reset mem_write", 64'(bus.mem_write), 64'd1);
    reset = 1'b1;
    #1;
    check("in-reset outs", 64'(dut_outs()), 64'd0);
    check("in-reset state", 64'(bus.state), 64'd0);
    check("in-reset instret", 64'(bus.instret), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_ret = '0;
    check("post-reset state", 64'(bus.state), 64'd0);
    check("post-reset mem_write", 64'(bus.mem_write), 64'd0);
    check("post-reset instret", 64'(bus.instret), 64'd0);
`ifdef MC_CTRL_TRAP_EN
    run_instr(6'b111000, 0, 0);
    begin
      outs_t o;
      cur_op = 6'b000000;
      q.delete();
      o = '0;
      o.mr = 1'b1;
      o.asb = 2'd1;
      for (int i = 0; i < 16; i++) push(4'd0, 1'b0, o);
      o = '0;
      o.trap = 1'b1;
      o.pcw = 1'b1;
      o.pcsrc = 2'd3;
      push(4'd12, 1'b0, o);
      foreach (q[i]) step(q[i]);
    end
`endif
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 4) == 0 ? 6'($urandom) : ops[$urandom_range(0, 16)];
      run_instr(op, $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0,
        $urandom_range(0, 1) == 0 ? $urandom_range(1, 4) : 0);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("final state", 64'(bus.state), 64'd0);
    check("final instret", 64'(bus.instret), 64'(n_ret));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
